pn_sequence_checker: RTL and testbench
======================================

# pn_sequence_checker

- Receiving end of the PN sequence generator's one-bit pseudo-noise stream. It self-synchronises a local LFSR to the incoming bits, declares lock, then free-runs and compares every later bit.
- Reports lock status, per-bit error pulses and saturating error/bit counters.
- Sits beside the DEM-DAC scrambler path as a loopback monitor for the dither/PN source.

## Interface
Parameters:
- LFSR_W, default 7: LFSR length; must match the generator.
- TAPS, default 7'b110_0000: feedback mask, x^7+x^6+1 (PRBS7).
- LOCK_COUNT, default 16: consecutive correct predictions required to lock.
- UNLOCK_ERRORS, default 4: consecutive mismatches while locked that force relock.
- CNT_W, default 16: width of both counters.

Ports:
- clk_i, input, 1: single clock.
- reset_ni, input, 1: asynchronous, active-low reset.
- pn_valid_i, input, 1: pn_seq_i carries a bit this cycle.
- pn_seq_i, input, 1: received PN bit.
- clear_i, input, 1: synchronous clear of err_count_o and bit_count_o.
- locked_o, output, 1: checker is in LOCKED.
- bit_err_o, output, 1: one-cycle pulse on a mismatched valid bit while locked.
- err_count_o, output, CNT_W: mismatches counted while locked; saturating.
- bit_count_o, output, CNT_W: valid bits checked while locked; saturating.

## Operation
- Shift register s[LFSR_W-1:0].
- Prediction p = ^(s & TAPS). Shift rule: s <= {s[LFSR_W-2:0], b}. This is the generator's Fibonacci convention.
- Only cycles with pn_valid_i=1 advance anything. With pn_valid_i=0 all state holds and bit_err_o=0.
- FSM states FILL, HUNT and LOCKED:
  - FILL: b = pn_seq_i. A fill counter counts to LFSR_W valid bits, then the FSM moves to HUNT with the match counter at 0.
  - HUNT: b = pn_seq_i. If p==pn_seq_i and s!=0, increment the match counter. Otherwise clear it; an all-zero register never counts toward lock. When the counter reaches LOCK_COUNT, go to LOCKED with the miss counter at 0.
  - LOCKED: b = p, so the register free-runs and input errors never corrupt it. If p!=pn_seq_i: pulse bit_err_o, increment err_count_o and the miss counter. Else clear the miss counter. Every valid bit increments bit_count_o. When the miss counter reaches UNLOCK_ERRORS, go to FILL.
- Counters:
  - Both saturate at all-ones.
  - Neither is cleared by lock loss.
  - clear_i wins over a simultaneous increment, leaving the result 0.
- Reset (any time, including mid-lock):
  - State = FILL, s=0, all internal counters 0.
  - locked_o=0, bit_err_o=0, err_count_o=0, bit_count_o=0.

## Timing
- Inputs are sampled on rising clk_i. All outputs are registered.
- bit_err_o and counter updates appear in the cycle after the sampling edge of the offending bit.
- Lock latency on a clean stream: locked_o rises after the edge that samples valid bit number LFSR_W+LOCK_COUNT, i.e. bit 23 by default.
- Unlock: locked_o falls after the edge that samples the UNLOCK_ERRORS-th consecutive mismatch. That bit is counted in err_count_o and pulses bit_err_o.
- The first bit sampled in FILL after unlock is loaded. No bit is dropped.
- Back-to-back valid bits are supported at full rate.
- reset_ni assertion forces all outputs low asynchronously. Deassertion is used synchronously.

## Structure
- Shared package pn_pkg holds:
  - state enum pn_chk_state_e (FILL, HUNT, LOCKED);
  - constants PN_LFSR_W=7 and PN_TAPS=7'b110_0000, also used by the generator;
  - function pn_next_bit(state, taps).
- No sub-module. It is one FSM plus the datapath in a single module.

## Test plan
- Reset: hold reset_ni=0 for 3 cycles with toggling inputs -> locked_o=0, bit_err_o=0, err_count_o=0, bit_count_o=0.
- Clean PRBS7 from the generator model, seed 7'h7F, continuous valid -> locked_o=1 one cycle after bit 23. After 254 more bits: err_count_o=0, bit_count_o=254.
- Single inverted bit 40 bits after lock -> exactly one bit_err_o pulse, err_count_o=1, locked_o stays 1. All following bits match.
- Four consecutive inverted bits while locked -> err_count_o=4 and locked_o falls after the 4th. Relock after 23 further clean bits; err_count_o remains 4.
- All-zero input with valid for 100 bits -> locked_o never rises. Random pn_valid_i gaps on a clean stream -> lock after 23 valid bits regardless of gaps.
- clear_i asserted in the same cycle as a mismatched bit -> err_count_o=0 the next cycle. reset_ni pulsed mid-lock -> all outputs 0 immediately, relock after 23 bits.

Source files
------------

// File: rtl/pn_pkg.sv
// Shared PN definitions for the generator and checker: checker FSM states, PRBS7 polynomial
// and the Fibonacci feedback helper.
package pn_pkg;

  typedef enum logic [1:0] {
    FILL   = 2'd0,
    HUNT   = 2'd1,
    LOCKED = 2'd2
  } pn_chk_state_e;

  localparam int unsigned PN_LFSR_W = 7;
  localparam logic [PN_LFSR_W-1:0] PN_TAPS = 7'b110_0000;

  // Feedback is computed on a fixed-width view so any LFSR up to 32 bits can share it.
  localparam int unsigned PN_FN_W = 32;

  function automatic logic pn_next_bit(input logic [PN_FN_W-1:0] state,
                                       input logic [PN_FN_W-1:0] taps);
    return ^(state & taps);
  endfunction

endpackage

// File: rtl/pn_sequence_checker.sv
// Self-synchronising PN stream checker: loads a local LFSR from the incoming bits, locks after a run
// of correct predictions, then free-runs and counts mismatches.
module pn_sequence_checker
  import pn_pkg::*;
#(
  parameter int unsigned LFSR_W        = PN_LFSR_W,
  parameter logic [LFSR_W-1:0] TAPS    = PN_TAPS,
  parameter int unsigned LOCK_COUNT    = 16,
  parameter int unsigned UNLOCK_ERRORS = 4,
  parameter int unsigned CNT_W         = 16
) (
  input  logic             clk_i,
  input  logic             reset_ni,
  input  logic             pn_valid_i,
  input  logic             pn_seq_i,
  input  logic             clear_i,
  output logic             locked_o,
  output logic             bit_err_o,
  output logic [CNT_W-1:0] err_count_o,
  output logic [CNT_W-1:0] bit_count_o
);

  localparam int unsigned FILL_W  = $clog2(LFSR_W + 1);
  localparam int unsigned MATCH_W = $clog2(LOCK_COUNT + 1);
  localparam int unsigned MISS_W  = $clog2(UNLOCK_ERRORS + 1);

  pn_chk_state_e     state, state_d;
  logic [LFSR_W-1:0] s;
  logic [FILL_W-1:0] fill_cnt;
  logic [MATCH_W-1:0] match_cnt;
  logic [MISS_W-1:0] miss_cnt;

  logic p, mismatch, hunt_ok, shift_bit;
  logic last_fill, last_match, last_miss;
  logic locked_d, bit_err_d, err_inc, bit_inc;

  assign p          = pn_next_bit(32'(s), 32'(TAPS));
  assign mismatch   = (p != pn_seq_i);
  // An all-zero register predicts zeros forever, so it is never allowed to count toward lock.
  assign hunt_ok    = !mismatch && (s != '0);
  assign shift_bit  = (state == LOCKED) ? p : pn_seq_i;
  assign last_fill  = (fill_cnt == FILL_W'(LFSR_W - 1));
  assign last_match = (match_cnt == MATCH_W'(LOCK_COUNT - 1));
  assign last_miss  = (miss_cnt == MISS_W'(UNLOCK_ERRORS - 1));

  // State register
  always_ff @(posedge clk_i or negedge reset_ni) begin
    if (!reset_ni) state <= FILL;
    else           state <= state_d;
  end

  // Next-state logic
  always_comb begin
    state_d = state;
    unique case (state)
      FILL:    if (pn_valid_i && last_fill) state_d = HUNT;
      HUNT:    if (pn_valid_i && hunt_ok && last_match) state_d = LOCKED;
      LOCKED:  if (pn_valid_i && mismatch && last_miss) state_d = FILL;
      default: state_d = FILL;
    endcase
  end

  // Output decode, registered below
  always_comb begin
    locked_d  = (state_d == LOCKED);
    bit_err_d = 1'b0;
    err_inc   = 1'b0;
    bit_inc   = 1'b0;
    if (pn_valid_i && (state == LOCKED)) begin
      bit_inc   = 1'b1;
      bit_err_d = mismatch;
      err_inc   = mismatch;
    end
  end

  // LFSR and sync counters; each counter is zero whenever its state is entered
  always_ff @(posedge clk_i or negedge reset_ni) begin
    if (!reset_ni) begin
      s         <= '0;
      fill_cnt  <= '0;
      match_cnt <= '0;
      miss_cnt  <= '0;
    end else if (pn_valid_i) begin
      s <= {s[LFSR_W-2:0], shift_bit};
      unique case (state)
        FILL:    fill_cnt  <= last_fill ? '0 : fill_cnt + FILL_W'(1);
        HUNT:    match_cnt <= (!hunt_ok || last_match) ? '0 : match_cnt + MATCH_W'(1);
        LOCKED:  miss_cnt  <= (!mismatch || last_miss) ? '0 : miss_cnt + MISS_W'(1);
        default: fill_cnt  <= '0;
      endcase
    end
  end

  // Registered status and saturating counters; clear beats a same-cycle increment
  always_ff @(posedge clk_i or negedge reset_ni) begin
    if (!reset_ni) begin
      locked_o    <= 1'b0;
      bit_err_o   <= 1'b0;
      err_count_o <= '0;
      bit_count_o <= '0;
    end else begin
      locked_o  <= locked_d;
      bit_err_o <= bit_err_d;
      if (clear_i) begin
        err_count_o <= '0;
        bit_count_o <= '0;
      end else begin
        if (err_inc && (err_count_o != '1)) err_count_o <= err_count_o + CNT_W'(1);
        if (bit_inc && (bit_count_o != '1)) bit_count_o <= bit_count_o + CNT_W'(1);
      end
    end
  end

endmodule

// File: tb/tb_pn_sequence_checker.sv
// Directed bench for pn_sequence_checker driven by a PRBS7 generator model (x^7+x^6+1, seed 7'h7F).
module tb_pn_sequence_checker;

  logic        clk_i;
  logic        reset_ni;
  logic        pn_valid_i;
  logic        pn_seq_i;
  logic        clear_i;
  logic        locked_o;
  logic        bit_err_o;
  logic [15:0] err_count_o;
  logic [15:0] bit_count_o;

  int   vectors;
  int   miscompares;
  int   pulses;
  logic seen_lock;
  logic [6:0] gen;

  pn_sequence_checker #(
    .LFSR_W(7), .TAPS(7'b110_0000), .LOCK_COUNT(16), .UNLOCK_ERRORS(4), .CNT_W(16)
  ) dut (
    .clk_i(clk_i), .reset_ni(reset_ni), .pn_valid_i(pn_valid_i), .pn_seq_i(pn_seq_i),
    .clear_i(clear_i), .locked_o(locked_o), .bit_err_o(bit_err_o),
    .err_count_o(err_count_o), .bit_count_o(bit_count_o)
  );

  initial clk_i = 1'b0;
  always #5 clk_i = ~clk_i;

  // Generator model: output = g[6]^g[5], shifted into the low end
  task automatic next_gen(output logic b);
    b   = gen[6] ^ gen[5];
    gen = {gen[5:0], b};
  endtask

  // Drive at a falling edge, return at the next falling edge with outputs settled
  task automatic step(input logic v, input logic b, input logic c);
    pn_valid_i = v;
    pn_seq_i   = b;
    clear_i    = c;
    @(negedge clk_i);
    pn_valid_i = 1'b0;
    clear_i    = 1'b0;
    if (bit_err_o) pulses++;
    if (locked_o) seen_lock = 1'b1;
  endtask

  task automatic send_clean(input int n);
    logic b;
    for (int i = 0; i < n; i++) begin
      next_gen(b);
      step(1'b1, b, 1'b0);
    end
  endtask

  task automatic send_bad();
    logic b;
    next_gen(b);
    step(1'b1, ~b, 1'b0);
  endtask

  task automatic pulse_reset();
    reset_ni = 1'b0;
    @(negedge clk_i);
    reset_ni = 1'b1;
  endtask

  task automatic test_reset();
    reset_ni = 1'b0;
    for (int i = 0; i < 3; i++) begin
      pn_valid_i = i[0];
      pn_seq_i   = ~i[0];
      clear_i    = i[1];
      @(negedge clk_i);
    end
    vectors++; if (locked_o !== 1'b0) begin miscompares++; $display("FAIL reset_locked: got %b want 0", locked_o); end
    vectors++; if (bit_err_o !== 1'b0) begin miscompares++; $display("FAIL reset_bit_err: got %b want 0", bit_err_o); end
    vectors++; if (err_count_o !== 16'd0) begin miscompares++; $display("FAIL reset_err_count: got %0d want 0", err_count_o); end
    vectors++; if (bit_count_o !== 16'd0) begin miscompares++; $display("FAIL reset_bit_count: got %0d want 0", bit_count_o); end
    pn_valid_i = 1'b0;
    clear_i    = 1'b0;
    reset_ni   = 1'b1;
  endtask

  task automatic test_clean_lock();
    pulses = 0;
    send_clean(22);
    vectors++; if (locked_o !== 1'b0) begin miscompares++; $display("FAIL lock_early: got %b want 0 after 22 bits", locked_o); end
    send_clean(1);
    vectors++; if (locked_o !== 1'b1) begin miscompares++; $display("FAIL lock_latency: got %b want 1 after 23 bits", locked_o); end
    send_clean(254);
    vectors++; if (err_count_o !== 16'd0) begin miscompares++; $display("FAIL clean_err_count: got %0d want 0", err_count_o); end
    vectors++; if (bit_count_o !== 16'd254) begin miscompares++; $display("FAIL clean_bit_count: got %0d want 254", bit_count_o); end
    vectors++; if (pulses !== 0) begin miscompares++; $display("FAIL clean_pulses: got %0d want 0", pulses); end
  endtask

  task automatic test_single_error();
    pulses = 0;
    send_clean(39);
    send_bad();
    vectors++; if (bit_err_o !== 1'b1) begin miscompares++; $display("FAIL single_pulse: got %b want 1", bit_err_o); end
    vectors++; if (err_count_o !== 16'd1) begin miscompares++; $display("FAIL single_err_count: got %0d want 1", err_count_o); end
    send_clean(20);
    vectors++; if (pulses !== 1) begin miscompares++; $display("FAIL single_pulse_total: got %0d want 1", pulses); end
    vectors++; if (locked_o !== 1'b1) begin miscompares++; $display("FAIL single_locked: got %b want 1", locked_o); end
    vectors++; if (bit_count_o !== 16'd314) begin miscompares++; $display("FAIL single_bit_count: got %0d want 314", bit_count_o); end
    vectors++; if (err_count_o !== 16'd1) begin miscompares++; $display("FAIL single_err_hold: got %0d want 1", err_count_o); end
  endtask

  task automatic test_unlock_relock();
    step(1'b0, 1'b0, 1'b1);
    vectors++; if (err_count_o !== 16'd0 || bit_count_o !== 16'd0) begin miscompares++; $display("FAIL clear_idle: got err=%0d bits=%0d want 0/0", err_count_o, bit_count_o); end
    for (int i = 0; i < 3; i++) send_bad();
    vectors++; if (locked_o !== 1'b1) begin miscompares++; $display("FAIL unlock_early: got %b want 1 after 3 misses", locked_o); end
    send_bad();
    vectors++; if (locked_o !== 1'b0) begin miscompares++; $display("FAIL unlock: got %b want 0 after 4 misses", locked_o); end
    vectors++; if (bit_err_o !== 1'b1) begin miscompares++; $display("FAIL unlock_pulse: got %b want 1", bit_err_o); end
    vectors++; if (err_count_o !== 16'd4) begin miscompares++; $display("FAIL unlock_err_count: got %0d want 4", err_count_o); end
    send_clean(22);
    vectors++; if (locked_o !== 1'b0) begin miscompares++; $display("FAIL relock_early: got %b want 0", locked_o); end
    send_clean(1);
    vectors++; if (locked_o !== 1'b1) begin miscompares++; $display("FAIL relock: got %b want 1 after 23 bits", locked_o); end
    vectors++; if (err_count_o !== 16'd4) begin miscompares++; $display("FAIL relock_err_count: got %0d want 4", err_count_o); end
    vectors++; if (bit_count_o !== 16'd4) begin miscompares++; $display("FAIL relock_bit_count: got %0d want 4", bit_count_o); end
  endtask

  task automatic test_zero_input();
    pulse_reset();
    seen_lock = 1'b0;
    pulses    = 0;
    for (int i = 0; i < 100; i++) step(1'b1, 1'b0, 1'b0);
    vectors++; if (seen_lock !== 1'b0) begin miscompares++; $display("FAIL zero_lock: got lock=%b want 0", seen_lock); end
    vectors++; if (bit_count_o !== 16'd0 || pulses !== 0) begin miscompares++; $display("FAIL zero_counts: got bits=%0d pulses=%0d want 0/0", bit_count_o, pulses); end
  endtask

  task automatic test_valid_gaps();
    logic b;
    pulse_reset();
    for (int i = 0; i < 23; i++) begin
      for (int g = 0; g < int'($urandom_range(3, 0)); g++) step(1'b0, 1'($urandom_range(1, 0)), 1'b0);
      if (i == 22) begin
        vectors++; if (locked_o !== 1'b0) begin miscompares++; $display("FAIL gap_lock_early: got %b want 0 after 22 valid", locked_o); end
      end
      next_gen(b);
      step(1'b1, b, 1'b0);
    end
    vectors++; if (locked_o !== 1'b1) begin miscompares++; $display("FAIL gap_lock: got %b want 1 after 23 valid", locked_o); end
    for (int g = 0; g < 4; g++) step(1'b0, 1'b1, 1'b0);
    vectors++; if (bit_count_o !== 16'd0 || locked_o !== 1'b1 || bit_err_o !== 1'b0) begin
      miscompares++; $display("FAIL gap_hold: got bits=%0d locked=%b err=%b want 0/1/0", bit_count_o, locked_o, bit_err_o);
    end
  endtask

  task automatic test_clear_collision();
    logic b;
    send_clean(5);
    vectors++; if (bit_count_o !== 16'd5) begin miscompares++; $display("FAIL pre_clear_bits: got %0d want 5", bit_count_o); end
    next_gen(b);
    step(1'b1, ~b, 1'b1);
    vectors++; if (err_count_o !== 16'd0 || bit_count_o !== 16'd0) begin miscompares++; $display("FAIL clear_collision: got err=%0d bits=%0d want 0/0", err_count_o, bit_count_o); end
    vectors++; if (bit_err_o !== 1'b1) begin miscompares++; $display("FAIL clear_pulse: got %b want 1", bit_err_o); end
    send_bad();
    vectors++; if (err_count_o !== 16'd1 || bit_count_o !== 16'd1) begin miscompares++; $display("FAIL post_clear: got err=%0d bits=%0d want 1/1", err_count_o, bit_count_o); end
  endtask

  task automatic test_reset_midlock();
    #2 reset_ni = 1'b0;
    #1;
    vectors++; if (locked_o !== 1'b0 || bit_err_o !== 1'b0 || err_count_o !== 16'd0 || bit_count_o !== 16'd0) begin
      miscompares++; $display("FAIL async_reset: got locked=%b err=%b ec=%0d bc=%0d want all 0", locked_o, bit_err_o, err_count_o, bit_count_o);
    end
    @(negedge clk_i);
    reset_ni = 1'b1;
    send_clean(22);
    vectors++; if (locked_o !== 1'b0) begin miscompares++; $display("FAIL reset_relock_early: got %b want 0", locked_o); end
    send_clean(1);
    vectors++; if (locked_o !== 1'b1) begin miscompares++; $display("FAIL reset_relock: got %b want 1", locked_o); end
  endtask

  initial begin
    vectors     = 0;
    miscompares = 0;
    pulses      = 0;
    seen_lock   = 1'b0;
    gen         = 7'h7F;
    reset_ni    = 1'b0;
    pn_valid_i  = 1'b0;
    pn_seq_i    = 1'b0;
    clear_i     = 1'b0;
    @(negedge clk_i);
    test_reset();
    test_clean_lock();
    test_single_error();
    test_unlock_relock();
    test_zero_input();
    test_valid_gaps();
    test_clear_collision();
    test_reset_midlock();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
